// File: rtl/rpi_serial_link.sv
// rpi_serial_link
// Bit-serial register bridge between a Raspberry Pi style shift/latch
// interface and a TI-side register file. The RPi lines are asynchronous to
// clk, so they are synchronized and edge-detected before any use.
//
// Write path (regsel 00/01): sclk edges shift sdata MSB first into an input
// shift register; an sle edge with exactly 8 bits counted publishes the byte
// to RD or RC. Any other count is a framing error and nothing is published.
//
// Read path (regsel 10/11): an sle edge snapshots TD or TC into an output
// shift register whose bit 0 drives rpi_sdata_in; each sclk edge shifts it
// toward bit 0 with zero fill.
//
// Vector convention: all byte-wide signals are [0:7] with bit 0 as MSB.

module rpi_serial_link (
  input  logic       clk,
  input  logic       rst,
  input  logic       rpi_sclk,
  input  logic       rpi_sle,
  input  logic [1:0] rpi_regsel,
  input  logic       rpi_sdata_out,
  output logic       rpi_sdata_in,
  input  logic [0:7] ti_td,
  input  logic [0:7] ti_tc,
  output logic [0:7] ti_dbus_rd,
  output logic [0:7] ti_dbus_rc,
  output logic       rd_upd,
  output logic       rc_upd,
  output logic       frame_err
);

  localparam logic [3:0] CNT_FULL = 4'd8;
  localparam logic [3:0] CNT_SAT  = 4'd9;

  localparam logic [1:0] SEL_RD = 2'b00;
  localparam logic [1:0] SEL_RC = 2'b01;
  localparam logic [1:0] SEL_TD = 2'b10;
  localparam logic [1:0] SEL_TC = 2'b11;

  // ---------------------------------------------------------------------
  // Synchronizers and edge history
  // ---------------------------------------------------------------------
  logic [1:0] sclk_sync_reg;
  logic [1:0] sle_sync_reg;
  logic [1:0] sdata_sync_reg;
  logic [1:0] regsel_s1_reg;
  logic [1:0] regsel_s2_reg;

  logic       sclk_hist_reg;
  logic       sle_hist_reg;
  logic [1:0] regsel_hist_reg;

  logic       sclk_s;
  logic       sle_s;
  logic       sdata_s;
  logic [1:0] regsel_s;

  logic       sclk_edge;
  logic       sle_edge;
  logic       sel_change;

  // Strobe synchronizers reset high so a line held high through reset
  // release is not mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_reg <= 2'b11;
      sle_sync_reg  <= 2'b11;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[0], rpi_sclk};
      sle_sync_reg  <= {sle_sync_reg[0], rpi_sle};
    end
  end

  // Data and select synchronizers; their reset value carries no meaning.
  always_ff @(posedge clk) begin
    if (rst) begin
      sdata_sync_reg <= 2'b00;
      regsel_s1_reg  <= 2'b00;
      regsel_s2_reg  <= 2'b00;
    end else begin
      sdata_sync_reg <= {sdata_sync_reg[0], rpi_sdata_out};
      regsel_s1_reg  <= rpi_regsel;
      regsel_s2_reg  <= regsel_s1_reg;
    end
  end

  assign sclk_s   = sclk_sync_reg[1];
  assign sle_s    = sle_sync_reg[1];
  assign sdata_s  = sdata_sync_reg[1];
  assign regsel_s = regsel_s2_reg;

  // One-cycle-delayed copies used for rising-edge and select-change detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_hist_reg   <= 1'b1;
      sle_hist_reg    <= 1'b1;
      regsel_hist_reg <= 2'b00;
    end else begin
      sclk_hist_reg   <= sclk_s;
      sle_hist_reg    <= sle_s;
      regsel_hist_reg <= regsel_s;
    end
  end

  assign sclk_edge  = sclk_s & ~sclk_hist_reg;
  assign sle_edge   = sle_s & ~sle_hist_reg;
  assign sel_change = (regsel_s != regsel_hist_reg);

  // ---------------------------------------------------------------------
  // Datapath state
  // ---------------------------------------------------------------------
  logic [0:7] isr_reg,    isr_next;
  logic [3:0] cnt_reg,    cnt_next;
  logic [0:7] osr_reg,    osr_next;
  logic [0:7] rd_reg,     rd_next;
  logic [0:7] rc_reg,     rc_next;
  logic       rd_upd_reg, rd_upd_next;
  logic       rc_upd_reg, rc_upd_next;
  logic       ferr_reg,   ferr_next;

  // Next-state logic. A latch strobe wins over a coincident shift clock,
  // which is dropped; a select change likewise swallows a coincident shift
  // on the write side so the new register always starts from an empty frame.
  always_comb begin
    isr_next    = isr_reg;
    cnt_next    = cnt_reg;
    osr_next    = osr_reg;
    rd_next     = rd_reg;
    rc_next     = rc_reg;
    rd_upd_next = 1'b0;
    rc_upd_next = 1'b0;
    ferr_next   = 1'b0;

    if (sle_edge) begin
      isr_next = '0;
      cnt_next = '0;
      unique case (regsel_s)
        SEL_RD: begin
          if (cnt_reg == CNT_FULL) begin
            rd_next     = isr_reg;
            rd_upd_next = 1'b1;
          end else begin
            ferr_next = 1'b1;
          end
        end
        SEL_RC: begin
          if (cnt_reg == CNT_FULL) begin
            rc_next     = isr_reg;
            rc_upd_next = 1'b1;
          end else begin
            ferr_next = 1'b1;
          end
        end
        SEL_TD: osr_next = ti_td;
        SEL_TC: osr_next = ti_tc;
        default: ;
      endcase
    end else begin
      if (sel_change) begin
        isr_next = '0;
        cnt_next = '0;
      end else if (sclk_edge) begin
        isr_next = {isr_reg[1:7], sdata_s};
        cnt_next = (cnt_reg == CNT_SAT) ? CNT_SAT : cnt_reg + 4'd1;
      end
      // The output register is independent of the select lines.
      if (sclk_edge) begin
        osr_next = {osr_reg[1:7], 1'b0};
      end
    end
  end

  // State register for the datapath and the registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      isr_reg    <= '0;
      cnt_reg    <= '0;
      osr_reg    <= '0;
      rd_reg     <= '0;
      rc_reg     <= '0;
      rd_upd_reg <= 1'b0;
      rc_upd_reg <= 1'b0;
      ferr_reg   <= 1'b0;
    end else begin
      isr_reg    <= isr_next;
      cnt_reg    <= cnt_next;
      osr_reg    <= osr_next;
      rd_reg     <= rd_next;
      rc_reg     <= rc_next;
      rd_upd_reg <= rd_upd_next;
      rc_upd_reg <= rc_upd_next;
      ferr_reg   <= ferr_next;
    end
  end

  // All outputs come straight from flops.
  assign rpi_sdata_in = osr_reg[0];
  assign ti_dbus_rd   = rd_reg;
  assign ti_dbus_rc   = rc_reg;
  assign rd_upd       = rd_upd_reg;
  assign rc_upd       = rc_upd_reg;
  assign frame_err    = ferr_reg;

endmodule

// File: tb/tb_rpi_serial_link.sv
// tb_rpi_serial_link
// Directed bench: a table of write/read transactions with hand-computed
// results, plus hand-written sequences for cycle-exact latch timing,
// select change mid-frame, coincident sclk/sle and reset mid-transfer.

module tb_rpi_serial_link;

  logic       clk = 1'b0;
  logic       rst;
  logic       rpi_sclk;
  logic       rpi_sle;
  logic [1:0] rpi_regsel;
  logic       rpi_sdata_out;
  logic       rpi_sdata_in;
  logic [7:0] ti_td;
  logic [7:0] ti_tc;
  logic [7:0] ti_dbus_rd;
  logic [7:0] ti_dbus_rc;
  logic       rd_upd;
  logic       rc_upd;
  logic       frame_err;

  always #10 clk = ~clk;

  rpi_serial_link dut (
    .clk          (clk),
    .rst          (rst),
    .rpi_sclk     (rpi_sclk),
    .rpi_sle      (rpi_sle),
    .rpi_regsel   (rpi_regsel),
    .rpi_sdata_out(rpi_sdata_out),
    .rpi_sdata_in (rpi_sdata_in),
    .ti_td        (ti_td),
    .ti_tc        (ti_tc),
    .ti_dbus_rd   (ti_dbus_rd),
    .ti_dbus_rc   (ti_dbus_rc),
    .rd_upd       (rd_upd),
    .rc_upd       (rc_upd),
    .frame_err    (frame_err)
  );

  int errors = 0;
  int checks = 0;

  // Pulse counters sampled on every clock edge.
  int n_rd = 0;
  int n_rc = 0;
  int n_fe = 0;

  always @(posedge clk) begin
    if (rd_upd === 1'b1)    n_rd <= n_rd + 1;
    if (rc_upd === 1'b1)    n_rc <= n_rc + 1;
    if (frame_err === 1'b1) n_fe <= n_fe + 1;
  end

  typedef struct {
    bit         rd_op;
    logic [1:0] sel;
    logic [7:0] val;
    int         nbits;
    logic [7:0] exp_rd;
    logic [7:0] exp_rc;
    int         e_rd;
    int         e_rc;
    int         e_fe;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_bit(input logic b);
    rpi_sdata_out = b;
    wait_cyc(2);
    rpi_sclk = 1'b1;
    wait_cyc(4);
    rpi_sclk = 1'b0;
    wait_cyc(4);
  endtask

  task automatic sle_pulse();
    rpi_sle = 1'b1;
    wait_cyc(4);
    rpi_sle = 1'b0;
    wait_cyc(4);
  endtask

  task automatic shift_byte(input logic [7:0] v, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sclk_bit((i < 8) ? v[7-i] : 1'b0);
    end
  endtask

  initial begin
    int rd0, rc0, fe0;
    logic [7:0] v;

    vecs[0] = '{1'b0, 2'b00, 8'hA5, 8, 8'hA5, 8'h00, 1, 0, 0};
    vecs[1] = '{1'b0, 2'b01, 8'h3C, 8, 8'hA5, 8'h3C, 0, 1, 0};
    vecs[2] = '{1'b0, 2'b01, 8'hFF, 7, 8'hA5, 8'h3C, 0, 0, 1};
    vecs[3] = '{1'b0, 2'b01, 8'hFF, 9, 8'hA5, 8'h3C, 0, 0, 1};
    vecs[4] = '{1'b0, 2'b00, 8'h00, 0, 8'hA5, 8'h3C, 0, 0, 1};
    vecs[5] = '{1'b0, 2'b00, 8'h00, 8, 8'h00, 8'h3C, 1, 0, 0};
    vecs[6] = '{1'b1, 2'b11, 8'hC3, 0, 8'h00, 8'h3C, 0, 0, 0};
    vecs[7] = '{1'b1, 2'b10, 8'h5A, 0, 8'h00, 8'h3C, 0, 0, 0};

    rst = 1'b1;
    rpi_sclk = 1'b0;
    rpi_sle = 1'b0;
    rpi_regsel = 2'b00;
    rpi_sdata_out = 1'b0;
    ti_td = 8'h00;
    ti_tc = 8'h00;

    // Reset state
    wait_cyc(4);
    check("reset_rd", ti_dbus_rd, 8'h00);
    check("reset_rc", ti_dbus_rc, 8'h00);
    check("reset_sdata_in", rpi_sdata_in, 1'b0);
    check("reset_pulses", {rd_upd, rc_upd, frame_err}, 3'b000);
    rst = 1'b0;
    rd0 = n_rd; rc0 = n_rc; fe0 = n_fe;
    wait_cyc(6);
    check("post_reset_no_pulse", (n_rd - rd0) + (n_rc - rc0) + (n_fe - fe0), 0);
    $display("txn reset: rd=%0h rc=%0h", ti_dbus_rd, ti_dbus_rc);

    // Cycle-exact latch timing: 0xA5 into RD, pulse only at edge N+2
    rpi_regsel = 2'b00;
    wait_cyc(5);
    shift_byte(8'hA5, 8);
    rpi_sle = 1'b1;
    @(posedge clk); #1;
    check("t033_upd_N", rd_upd, 1'b0);
    @(posedge clk); #1;
    check("t033_upd_N1", rd_upd, 1'b0);
    check("t033_rd_N1", ti_dbus_rd, 8'h00);
    @(posedge clk); #1;
    check("t033_upd_N2", rd_upd, 1'b1);
    check("t033_rd_N2", ti_dbus_rd, 8'hA5);
    check("t033_rc", ti_dbus_rc, 8'h00);
    @(posedge clk); #1;
    check("t033_upd_N3", rd_upd, 1'b0);
    @(negedge clk);
    rpi_sle = 1'b0;
    wait_cyc(4);
    $display("txn timing_rd: rd=%0h rc=%0h", ti_dbus_rd, ti_dbus_rc);

    // Table-driven transactions
    for (int t = 0; t < 8; t++) begin
      rd0 = n_rd; rc0 = n_rc; fe0 = n_fe;
      if (vecs[t].rd_op) begin
        v = vecs[t].val;
        ti_td = v;
        ti_tc = v;
        rpi_regsel = vecs[t].sel;
        wait_cyc(5);
        sle_pulse();
        // Later changes on the TI latches must not disturb the snapshot.
        ti_td = ~v;
        ti_tc = ~v;
        check($sformatf("v%0d_bit0", t), rpi_sdata_in, v[7]);
        for (int k = 1; k <= 8; k++) begin
          sclk_bit(1'b1);
          check($sformatf("v%0d_bit%0d", t, k), rpi_sdata_in, (k < 8) ? v[7-k] : 1'b0);
        end
      end else begin
        rpi_regsel = vecs[t].sel;
        wait_cyc(5);
        shift_byte(vecs[t].val, vecs[t].nbits);
        sle_pulse();
      end
      check($sformatf("v%0d_rd", t), ti_dbus_rd, vecs[t].exp_rd);
      check($sformatf("v%0d_rc", t), ti_dbus_rc, vecs[t].exp_rc);
      check($sformatf("v%0d_pulses", t), {n_rd - rd0, n_rc - rc0, n_fe - fe0},
            {vecs[t].e_rd, vecs[t].e_rc, vecs[t].e_fe});
      $display("txn %0d: %s sel=%0d val=%0h nbits=%0d rd=%0h rc=%0h upd_rd=%0d upd_rc=%0d ferr=%0d",
               t, vecs[t].rd_op ? "read" : "write", vecs[t].sel, vecs[t].val, vecs[t].nbits,
               ti_dbus_rd, ti_dbus_rc, n_rd - rd0, n_rc - rc0, n_fe - fe0);
    end

    // Select change mid-frame restarts the frame
    rd0 = n_rd; rc0 = n_rc; fe0 = n_fe;
    rpi_regsel = 2'b00;
    wait_cyc(5);
    shift_byte(8'hA0, 4);
    rpi_regsel = 2'b01;
    wait_cyc(5);
    shift_byte(8'hFF, 8);
    sle_pulse();
    check("t036_rc", ti_dbus_rc, 8'hFF);
    check("t036_rd", ti_dbus_rd, 8'h00);
    check("t036_pulses", {n_rd - rd0, n_rc - rc0, n_fe - fe0}, {32'd0, 32'd1, 32'd0});
    $display("txn regsel_change: rd=%0h rc=%0h", ti_dbus_rd, ti_dbus_rc);

    // Coincident sclk and sle: the latch wins, the extra bit is dropped
    rd0 = n_rd; rc0 = n_rc; fe0 = n_fe;
    rpi_regsel = 2'b00;
    wait_cyc(5);
    shift_byte(8'h96, 8);
    rpi_sdata_out = 1'b1;
    rpi_sclk = 1'b1;
    rpi_sle = 1'b1;
    wait_cyc(4);
    rpi_sclk = 1'b0;
    rpi_sle = 1'b0;
    wait_cyc(4);
    check("t037_rd", ti_dbus_rd, 8'h96);
    check("t037_pulses", {n_rd - rd0, n_rc - rc0, n_fe - fe0}, {32'd1, 32'd0, 32'd0});
    rd0 = n_rd; fe0 = n_fe;
    sle_pulse();
    check("t037_followup_ferr", {n_rd - rd0, n_fe - fe0}, {32'd0, 32'd1});
    $display("txn coincident: rd=%0h rc=%0h", ti_dbus_rd, ti_dbus_rc);

    // Reset mid-transfer with sclk and sle held high across release
    ti_td = 8'hFF;
    rpi_regsel = 2'b10;
    wait_cyc(5);
    sle_pulse();
    rpi_regsel = 2'b00;
    wait_cyc(5);
    shift_byte(8'hF8, 5);
    check("t038_sdata_before_rst", rpi_sdata_in, 1'b1);
    rst = 1'b1;
    rpi_sclk = 1'b1;
    rpi_sle = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    rd0 = n_rd; rc0 = n_rc; fe0 = n_fe;
    wait_cyc(8);
    check("t038_outputs", {ti_dbus_rd, ti_dbus_rc, 7'd0, rpi_sdata_in}, 24'h000000);
    check("t038_no_pulse", {n_rd - rd0, n_rc - rc0, n_fe - fe0}, {32'd0, 32'd0, 32'd0});
    rpi_sclk = 1'b0;
    rpi_sle = 1'b0;
    wait_cyc(4);
    sle_pulse();
    check("t038_first_sle_ferr", {n_rd - rd0, n_rc - rc0, n_fe - fe0}, {32'd0, 32'd0, 32'd1});
    check("t038_rd_after", ti_dbus_rd, 8'h00);
    $display("txn reset_mid: rd=%0h rc=%0h sdata_in=%0b", ti_dbus_rd, ti_dbus_rc, rpi_sdata_in);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
